forwarding_tracker: RTL and testbench

FORWARDING_TRACKER -- requirements
Module: forwarding_tracker

---
 rtl/forwarding_tracker.sv | 102 ++++++++++
 tb/tb_forwarding_tracker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_tracker.sv
// Tracks in-flight register producers and picks the forwarding source for each consumer operand.
// Optional load-use stall logic is compiled in when FWD_LOAD_STALL_EN is defined.
module forwarding_tracker #(
    parameter int DEPTH     = 2,
    parameter int REG_AW    = 4,
    parameter int NOFWD_REG = 15,
    localparam int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_wb_en,
    input  logic              issue_is_load,
    input  logic [REG_AW-1:0] issue_dst,
    input  logic [REG_AW-1:0] src_1,
    input  logic [REG_AW-1:0] src_2,
    input  logic              src_1_used,
    input  logic              src_2_used,
    output logic [SEL_W-1:0]  sel_src_1,
    output logic [SEL_W-1:0]  sel_src_2,
    output logic              hazard_stall
);

    localparam logic [REG_AW-1:0] NOFWD = REG_AW'(NOFWD_REG);

    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  wb_en_reg;
    logic [REG_AW-1:0] dst_reg [DEPTH];
    logic [DEPTH-1:0]  match_1;
    logic [DEPTH-1:0]  match_2;
    logic [SEL_W-1:0]  sel_1_raw;
    logic [SEL_W-1:0]  sel_2_raw;

    // Per-entry match against each consumer source; the PC index never forwards.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match_1[gi] = valid_reg[gi] & wb_en_reg[gi] & src_1_used
                           & (dst_reg[gi] == src_1) & (src_1 != NOFWD);
        assign match_2[gi] = valid_reg[gi] & wb_en_reg[gi] & src_2_used
                           & (dst_reg[gi] == src_2) & (src_2 != NOFWD);
    end

    // Scan oldest to youngest so the youngest producer overwrites the selection.
    always_comb begin
        sel_1_raw = '0;
        sel_2_raw = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_1[k]) sel_1_raw = SEL_W'(k + 1);
            if (match_2[k]) sel_2_raw = SEL_W'(k + 1);
        end
    end

`ifdef FWD_LOAD_STALL_EN
    logic [DEPTH-1:0] is_load_reg;
    logic             load_hit_1;
    logic             load_hit_2;

    // Load data is not ready while the load sits in the youngest slot.
    assign load_hit_1   = match_1[0] & is_load_reg[0];
    assign load_hit_2   = match_2[0] & is_load_reg[0];
    assign hazard_stall = load_hit_1 | load_hit_2;
    assign sel_src_1    = load_hit_1 ? '0 : sel_1_raw;
    assign sel_src_2    = load_hit_2 ? '0 : sel_2_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_reg <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                is_load_reg[k] <= is_load_reg[k-1];
            end
            is_load_reg[0] <= issue_is_load;
        end
    end
`else
    logic unused_is_load;

    assign unused_is_load = issue_is_load;
    assign hazard_stall   = 1'b0;
    assign sel_src_1      = sel_1_raw;
    assign sel_src_2      = sel_2_raw;
`endif

    // Shift register of producers; a squashed or stalled issue enters as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            wb_en_reg <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_reg[k] <= valid_reg[k-1];
                wb_en_reg[k] <= wb_en_reg[k-1];
                dst_reg[k]   <= dst_reg[k-1];
            end
            valid_reg[0] <= issue_valid & ~flush & ~hazard_stall;
            wb_en_reg[0] <= issue_wb_en;
            dst_reg[0]   <= issue_dst;
        end
    end

endmodule

// File: tb/tb_forwarding_tracker.sv
// Self-checking bench for forwarding_tracker: directed scenarios plus randomized traffic
// checked against a queue-based producer-history model.
module tb_forwarding_tracker;
    localparam int DEPTH = 2;
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, freeze, flush;
    logic             issue_valid, issue_wb_en, issue_is_load;
    logic [3:0]       issue_dst, src_1, src_2;
    logic             src_1_used, src_2_used;
    logic [SEL_W-1:0] sel_src_1, sel_src_2;
    logic             hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       valid;
        logic       wb_en;
        logic       is_load;
        logic [3:0] dst;
    } ent_t;

    ent_t hist[$];

    forwarding_tracker #(.DEPTH(DEPTH), .REG_AW(4), .NOFWD_REG(15)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_is_load(issue_is_load), .issue_dst(issue_dst),
        .src_1(src_1), .src_2(src_2),
        .src_1_used(src_1_used), .src_2_used(src_2_used),
        .sel_src_1(sel_src_1), .sel_src_2(sel_src_2),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic wb, input logic ld, input logic [3:0] d);
        issue_valid   = v;
        issue_wb_en   = wb;
        issue_is_load = ld;
        issue_dst     = d;
    endtask

    task automatic srcs(input logic [3:0] a, input logic ua, input logic [3:0] b, input logic ub);
        src_1      = a;
        src_1_used = ua;
        src_2      = b;
        src_2_used = ub;
    endtask

    task automatic test_reset;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        issue(0, 0, 0, 0);
        srcs(0, 1, 0, 1);
        tick; tick;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL reset_sel1: got %0d expected 0", sel_src_1); end
        n_checks++; if (sel_src_2 !== 0) begin n_fail++; $display("FAIL reset_sel2: got %0d expected 0", sel_src_2); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", hazard_stall); end
        rst = 1'b0;
        tick;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL post_reset_sel1: got %0d expected 0", sel_src_1); end
    endtask

    task automatic test_forward_age;
        srcs(0, 0, 0, 0);
        issue(1, 1, 0, 3);
        tick;
        issue(0, 0, 0, 0);
        srcs(3, 1, 0, 0);
        #1;
        n_checks++; if (sel_src_1 !== 1) begin n_fail++; $display("FAIL age_e0: got %0d expected 1", sel_src_1); end
        tick;
        n_checks++; if (sel_src_1 !== 2) begin n_fail++; $display("FAIL age_e1: got %0d expected 2", sel_src_1); end
        tick;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL age_retired: got %0d expected 0", sel_src_1); end
    endtask

    task automatic test_youngest_wins;
        srcs(0, 0, 0, 0);
        issue(1, 1, 0, 5);
        tick; tick;
        issue(0, 0, 0, 0);
        srcs(0, 0, 5, 1);
        #1;
        n_checks++; if (sel_src_2 !== 1) begin n_fail++; $display("FAIL youngest_sel2: got %0d expected 1", sel_src_2); end
        srcs(5, 1, 5, 1);
        #1;
        n_checks++; if (sel_src_1 !== 1) begin n_fail++; $display("FAIL same_src_sel1: got %0d expected 1", sel_src_1); end
        n_checks++; if (sel_src_2 !== 1) begin n_fail++; $display("FAIL same_src_sel2: got %0d expected 1", sel_src_2); end
    endtask

    task automatic test_no_forward;
        srcs(0, 0, 0, 0);
        issue(1, 1, 0, 15);
        tick;
        issue(1, 0, 0, 7);
        tick;
        issue(0, 0, 0, 0);
        srcs(15, 1, 7, 1);
        #1;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL nofwd_pc: got %0d expected 0", sel_src_1); end
        n_checks++; if (sel_src_2 !== 0) begin n_fail++; $display("FAIL nofwd_wben0: got %0d expected 0", sel_src_2); end
        issue(1, 1, 0, 8);
        tick;
        issue(0, 0, 0, 0);
        srcs(8, 0, 8, 1);
        #1;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL unused_src: got %0d expected 0", sel_src_1); end
        n_checks++; if (sel_src_2 !== 1) begin n_fail++; $display("FAIL used_src: got %0d expected 1", sel_src_2); end
    endtask

    task automatic test_freeze_flush;
        srcs(0, 0, 0, 0);
        issue(1, 1, 0, 2);
        tick;
        issue(1, 1, 0, 9);
        freeze = 1'b1;
        srcs(2, 1, 9, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (sel_src_1 !== 1) begin n_fail++; $display("FAIL freeze_hold cyc%0d: got %0d expected 1", i, sel_src_1); end
            n_checks++; if (sel_src_2 !== 0) begin n_fail++; $display("FAIL freeze_noissue cyc%0d: got %0d expected 0", i, sel_src_2); end
        end
        freeze = 1'b0;
        issue(1, 1, 0, 6);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        issue(0, 0, 0, 0);
        srcs(6, 1, 2, 1);
        #1;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL flush_bubble: got %0d expected 0", sel_src_1); end
        n_checks++; if (sel_src_2 !== 2) begin n_fail++; $display("FAIL flush_shift: got %0d expected 2", sel_src_2); end
    endtask

    task automatic test_load_use;
        srcs(0, 0, 0, 0);
        issue(1, 1, 1, 4);
        tick;
`ifdef FWD_LOAD_STALL_EN
        issue(1, 1, 0, 9);
        srcs(4, 1, 0, 0);
        #1;
        n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall: got %0b expected 1", hazard_stall); end
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL load_stall_sel: got %0d expected 0", sel_src_1); end
        tick;
        issue(0, 0, 0, 0);
        srcs(4, 1, 9, 1);
        #1;
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL load_release: got %0b expected 0", hazard_stall); end
        n_checks++; if (sel_src_1 !== 2) begin n_fail++; $display("FAIL load_fwd_e1: got %0d expected 2", sel_src_1); end
        n_checks++; if (sel_src_2 !== 0) begin n_fail++; $display("FAIL stall_bubble: got %0d expected 0", sel_src_2); end
        srcs(0, 0, 0, 0);
        issue(1, 1, 1, 4);
        tick;
        issue(0, 0, 0, 0);
        srcs(4, 1, 0, 0);
        #1;
        n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL midstall_pre: got %0b expected 1", hazard_stall); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL midstall_reset: got %0b expected 0", hazard_stall); end
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL midstall_sel: got %0d expected 0", sel_src_1); end
`else
        issue(0, 0, 0, 0);
        srcs(4, 1, 0, 0);
        #1;
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL load_nostall: got %0b expected 0", hazard_stall); end
        n_checks++; if (sel_src_1 !== 1) begin n_fail++; $display("FAIL load_fwd_e0: got %0d expected 1", sel_src_1); end
        tick;
        n_checks++; if (sel_src_1 !== 2) begin n_fail++; $display("FAIL load_fwd_e1: got %0d expected 2", sel_src_1); end
`endif
    endtask

    task automatic test_reset_all_valid;
        srcs(0, 0, 0, 0);
        issue(1, 1, 1, 1);
        tick;
        issue(1, 1, 0, 1);
        tick;
        issue(0, 0, 0, 0);
        srcs(1, 1, 1, 1);
        #1;
        n_checks++; if (sel_src_1 !== 1) begin n_fail++; $display("FAIL prefill_sel1: got %0d expected 1", sel_src_1); end
        rst = 1'b1;
        freeze = 1'b1;
        tick;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL rst_full_sel1: got %0d expected 0", sel_src_1); end
        n_checks++; if (sel_src_2 !== 0) begin n_fail++; $display("FAIL rst_full_sel2: got %0d expected 0", sel_src_2); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rst_full_stall: got %0b expected 0", hazard_stall); end
        rst = 1'b0;
        freeze = 1'b0;
        tick;
        n_checks++; if (sel_src_1 !== 0) begin n_fail++; $display("FAIL after_rst_sel1: got %0d expected 0", sel_src_1); end
    endtask

    function automatic logic [3:0] pick_reg();
        if ($urandom_range(0, 4) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    // Index of the youngest producer that supplies register s, or -1 if none.
    function automatic int find_producer(input logic [3:0] s, input logic used);
        if (!used || s == 4'd15) return -1;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].valid && hist[i].wb_en && hist[i].dst == s) return i;
        end
        return -1;
    endfunction

    task automatic test_random;
        int   p1, p2;
        int   exp1, exp2;
        logic exp_stall;
        ent_t e;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        issue(0, 0, 0, 0);
        srcs(0, 0, 0, 0);
        tick;
        rst = 1'b0;
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('{valid: 1'b0, wb_en: 1'b0, is_load: 1'b0, dst: 4'd0});
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst    = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, pick_reg());
            srcs(pick_reg(), $urandom_range(0, 4) != 0, pick_reg(), $urandom_range(0, 4) != 0);
            #1;
            p1 = find_producer(src_1, src_1_used);
            p2 = find_producer(src_2, src_2_used);
            exp1 = p1 + 1;
            exp2 = p2 + 1;
            exp_stall = 1'b0;
`ifdef FWD_LOAD_STALL_EN
            if (p1 == 0 && hist[0].is_load) begin exp1 = 0; exp_stall = 1'b1; end
            if (p2 == 0 && hist[0].is_load) begin exp2 = 0; exp_stall = 1'b1; end
`endif
            n_checks++; if (int'(sel_src_1) != exp1) begin n_fail++; $display("FAIL rand_sel1 cyc%0d: got %0d expected %0d", cyc, sel_src_1, exp1); end
            n_checks++; if (int'(sel_src_2) != exp2) begin n_fail++; $display("FAIL rand_sel2 cyc%0d: got %0d expected %0d", cyc, sel_src_2, exp2); end
            n_checks++; if (hazard_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall cyc%0d: got %0b expected %0b", cyc, hazard_stall, exp_stall); end
            e.valid   = issue_valid & ~flush & ~exp_stall;
            e.wb_en   = issue_wb_en;
            e.is_load = issue_is_load;
            e.dst     = issue_dst;
            @(posedge clk);
            if (rst) begin
                foreach (hist[i]) hist[i].valid = 1'b0;
            end else if (!freeze) begin
                hist.push_front(e);
                void'(hist.pop_back());
            end
            #1;
        end
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_age();
        test_youngest_wins();
        test_no_forward();
        test_freeze_flush();
        test_load_use();
        test_reset_all_valid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
